gateway_rx_cfg_ctrl: RTL
========================

# gateway_rx_cfg_ctrl

Host-facing configuration sequencer for the per-vFPGA RX gateways in the VIU. It accepts capability and identity commands over a valid/ready handshake and drives one persistent 14-bit `route_ctrl` word per vFPGA lane. Each word is held for a guaranteed number of cycles so the gateway's registered capability-table write lands. It keeps a shadow copy of every lane's identity and allowed-source slots for host readback, and reports per-command status.

## Interface
Parameters:
- `N_VFPGA`, default 4: number of gateway lanes, 1..16.
- `N_SLOTS`, default 4: capability slots per lane, 1..4.
- `HOLD_CYCLES`, default 2: cycles each driven word is held, at least 2.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_op`  in  2  operation code:
  - 00 = WRITE_SLOT
  - 01 = CLEAR_LANE
  - 10 = SET_IDENTITY
  - 11 = CLEAR_ALL
- `cmd_vfpga`  in  4  target lane index; ignored for CLEAR_ALL.
- `cmd_slot`  in  2  capability slot; WRITE_SLOT only.
- `cmd_src`  in  6  allowed source, {node[1:0], vfpga[3:0]}; WRITE_SLOT only.
- `cmd_self`  in  6  lane identity, {node[1:0], vfpga[3:0]}; SET_IDENTITY only.
- `route_ctrl`  out  N_VFPGA×14  per-lane word, {src_node, src_vfpga, self_node, self_vfpga, slot}.
- `rsp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `rsp_status`  out  2  completion status:
  - 00 = OK
  - 01 = bad lane
  - 10 = bad slot
  - 11 = zero identity
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err_count`  out  8  saturating count of rejected commands.
- `rd_vfpga`  in  4  shadow readback lane.
- `rd_slot`  in  2  shadow readback slot.
- `rd_src`  out  6  shadow allowed source at [rd_vfpga][rd_slot].
- `rd_self`  out  6  shadow identity of rd_vfpga.

## Operation
- **FSM states**
  - IDLE: `cmd_ready`=1. A handshake latches the command and validates it.
    - Invalid command → CHECK_FAIL.
    - WRITE_SLOT or SET_IDENTITY → DRIVE.
    - CLEAR_LANE or CLEAR_ALL → SWEEP.
  - DRIVE: the target lane word is updated on entry, then held for HOLD_CYCLES cycles → RESP.
  - SWEEP: slot index k runs 0..N_SLOTS-1. For each k, the word is {6'b0, self, k}, held HOLD_CYCLES cycles.
    - CLEAR_LANE applies this to the target lane only.
    - CLEAR_ALL applies it to all lanes in parallel.
    - After the last slot → RESP.
  - CHECK_FAIL: one cycle; increments `err_count`, saturating at 255 → RESP.
  - RESP: `rsp_valid`=1 with the latched status → IDLE.
- **Validation, in priority order**
  - Lane check (all ops except CLEAR_ALL): `cmd_vfpga` ≥ N_VFPGA → 01.
  - WRITE_SLOT: `cmd_slot` ≥ N_SLOTS → 10.
  - SET_IDENTITY: `cmd_self` == 0 → 11. The gateway ignores a zero identity, so it is rejected.
- **Word contents**
  - WRITE_SLOT drives {cmd_src, self[lane], cmd_slot}.
  - SET_IDENTITY drives {current src field, cmd_self, current slot field}. Re-driving the current slot/src pair is idempotent.
  - Every driven word carries the lane's current identity in bits [7:2].
- **Idle behaviour**
  - Words are never returned to zero while idle. Each lane holds its last word, because the gateway rewrites the same slot every cycle.
  - Lanes not targeted by a command keep their word unchanged.
- **Shadow tables** are updated on DRIVE/SWEEP entry, in the same cycle `route_ctrl` changes.
  - A rejected command changes nothing except `err_count`.
- **Readback** (`rd_src`, `rd_self`) is registered with 1-cycle latency.
  - An out-of-range `rd_vfpga` or `rd_slot` returns 0.

## Timing
- **Reset values:** `route_ctrl` all 0, shadows 0, `rsp_valid` 0, `rsp_status` 00, `busy` 0, `err_count` 0, `rd_*` 0, `cmd_ready` 0 while `aresetn` is low.
- **Reset mid-command:** abandons the command, produces no `rsp_valid`, and restores all reset values. `cmd_ready`=1 in the first cycle after `aresetn` rises.
- **Handshake at edge T:**
  - WRITE_SLOT / SET_IDENTITY: word visible at T+1, `rsp_valid` at T+1+HOLD_CYCLES, `cmd_ready` high at T+2+HOLD_CYCLES.
  - CLEAR_LANE / CLEAR_ALL: slot k word visible from T+1+k·HOLD_CYCLES; `rsp_valid` at T+1+N_SLOTS·HOLD_CYCLES.
  - Rejected command: `rsp_valid` at T+2, `cmd_ready` at T+3.
- `cmd_*` inputs are don't-care while `cmd_ready`=0. The command is latched at the handshake.
- **Back-to-back commands:** one command in flight at a time. A new command can be accepted in the cycle after RESP.
- **Readback during a command:** returns the updated shadow from the cycle after the word is driven.

## Test plan
- **WRITE_SLOT:** reset, SET_IDENTITY lane1 self=6'h12, then WRITE_SLOT lane1 slot2 src=6'h25 with HOLD_CYCLES=2 → `route_ctrl[1]`=14'h2 5·4A-form {6'h25, 6'h12, 2'd2} for ≥2 cycles; `rsp_status`=00 at T+3; `rd_src[1][2]`=6'h25.
- **CLEAR_LANE:** after the above, CLEAR_LANE lane1 → `route_ctrl[1]` src field=0 with slot=0,1,2,3, each held 2 cycles; `rsp_valid` at T+9; lane0 word unchanged.
- **Rejected commands:** WRITE_SLOT lane=N_VFPGA → status 01; slot=N_SLOTS with N_SLOTS=3 → status 10; SET_IDENTITY self=0 → status 11.
  - In all three cases `route_ctrl` is unchanged and `err_count` increments.
  - 260 consecutive rejects → `err_count` stays at 255.
- **CLEAR_ALL:** all lanes sweep in parallel; `busy` high for exactly N_SLOTS·HOLD_CYCLES+1 cycles; each lane's identity field is preserved.
- **Reset mid-SWEEP:** assert `aresetn`=0 mid-SWEEP → no `rsp_valid`; all words and shadows read 0; `cmd_ready`=1 one cycle after release.
- **Back-to-back stream:** 8 WRITE_SLOT commands with `cmd_valid` held high → exactly 8 `rsp_valid` pulses, spaced HOLD_CYCLES+2 cycles apart.

Source files
------------

// File: rtl/gateway_rx_cfg_ctrl.sv
// Host-side configuration sequencer for the per-vFPGA RX gateways: drives persistent
// route_ctrl words, keeps a readback shadow of identities and allowed sources.
module gateway_rx_cfg_ctrl #(
  parameter int N_VFPGA     = 4,
  parameter int N_SLOTS     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [3:0]             cmd_vfpga,
  input  logic [1:0]             cmd_slot,
  input  logic [5:0]             cmd_src,
  input  logic [5:0]             cmd_self,
  output logic [N_VFPGA*14-1:0]  route_ctrl,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_status,
  output logic                   busy,
  output logic [7:0]             err_count,
  input  logic [3:0]             rd_vfpga,
  input  logic [1:0]             rd_slot,
  output logic [5:0]             rd_src,
  output logic [5:0]             rd_self
);

  localparam int              HW        = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [1:0]      SLOT_LAST = 2'(N_SLOTS - 1);
  localparam logic [4:0]      LANE_LIM  = 5'(N_VFPGA);
  localparam logic [2:0]      SLOT_LIM  = 3'(N_SLOTS);

  localparam logic [1:0] OP_WRITE     = 2'b00;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;
  localparam logic [1:0] OP_SET_ID    = 2'b10;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_BAD_LANE  = 2'b01;
  localparam logic [1:0] ST_BAD_SLOT  = 2'b10;
  localparam logic [1:0] ST_ZERO_ID   = 2'b11;

  typedef enum logic [2:0] {IDLE, DRIVE, SWEEP, CHECK_FAIL, RESP} state_e;

  state_e                 state_q;
  logic [1:0]             op_q;
  logic [3:0]             lane_q;
  logic [1:0]             status_q;
  logic [HW-1:0]          hold_q;
  logic [1:0]             k_q;

  // Storage is sized for the 4-bit lane / 2-bit slot address space; lanes and
  // slots beyond the parameters are never written and stay zero.
  logic [15:0][13:0]      word_q;
  logic [15:0][5:0]       self_sh;
  logic [15:0][3:0][5:0]  src_sh;

  logic                   hs;
  logic [1:0]             chk_status;
  logic                   sweep_load;
  logic                   sweep_all;
  logic [3:0]             sweep_lane;
  logic [1:0]             sweep_k;

  // Command channel: a command transfers on a rising aclk edge where cmd_valid and
  // cmd_ready are both high; cmd_* are only sampled then. rsp_valid has no ready.
  assign hs = cmd_valid && cmd_ready;

  always_comb begin
    chk_status = ST_OK;
    if (cmd_op != OP_CLEAR_ALL && {1'b0, cmd_vfpga} >= LANE_LIM)
      chk_status = ST_BAD_LANE;
    else if (cmd_op == OP_WRITE && {1'b0, cmd_slot} >= SLOT_LIM)
      chk_status = ST_BAD_SLOT;
    else if (cmd_op == OP_SET_ID && cmd_self == 6'd0)
      chk_status = ST_ZERO_ID;
  end

  // Slot-k sweep word load: k=0 at acceptance, then each time a hold window expires.
  always_comb begin
    sweep_load = 1'b0;
    sweep_all  = (op_q == OP_CLEAR_ALL);
    sweep_lane = lane_q;
    sweep_k    = 2'd0;
    if (state_q == IDLE) begin
      sweep_load = hs && (chk_status == ST_OK) && cmd_op[0];
      sweep_all  = (cmd_op == OP_CLEAR_ALL);
      sweep_lane = cmd_vfpga;
    end else if (state_q == SWEEP) begin
      sweep_load = (hold_q == HOLD_LAST) && (k_q != SLOT_LAST);
      sweep_k    = k_q + 2'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      err_count  <= 8'd0;
      op_q       <= 2'd0;
      lane_q     <= 4'd0;
      status_q   <= ST_OK;
      hold_q     <= '0;
      k_q        <= 2'd0;
      word_q     <= '0;
      self_sh    <= '0;
      src_sh     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (hs) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= cmd_op;
            lane_q    <= cmd_vfpga;
            status_q  <= chk_status;
            hold_q    <= '0;
            k_q       <= 2'd0;
            if (chk_status != ST_OK) begin
              state_q <= CHECK_FAIL;
            end else if (cmd_op[0]) begin
              state_q <= SWEEP;
            end else begin
              state_q <= DRIVE;
              if (cmd_op == OP_WRITE) begin
                word_q[cmd_vfpga]           <= {cmd_src, self_sh[cmd_vfpga], cmd_slot};
                src_sh[cmd_vfpga][cmd_slot] <= cmd_src;
              end else begin
                // Keep the src/slot pair so the gateway rewrites the same entry.
                word_q[cmd_vfpga]  <= {word_q[cmd_vfpga][13:8], cmd_self, word_q[cmd_vfpga][1:0]};
                self_sh[cmd_vfpga] <= cmd_self;
              end
            end
          end
        end
        DRIVE: begin
          if (hold_q == HOLD_LAST) begin
            state_q    <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= status_q;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        SWEEP: begin
          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (k_q == SLOT_LAST) begin
              state_q    <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= status_q;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        CHECK_FAIL: begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state_q    <= RESP;
          rsp_valid  <= 1'b1;
          rsp_status <= status_q;
        end
        RESP: begin
          state_q   <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (sweep_load) begin
        if (sweep_all) begin
          for (int i = 0; i < N_VFPGA; i++) begin
            word_q[4'(i)]          <= {6'd0, self_sh[4'(i)], sweep_k};
            src_sh[4'(i)][sweep_k] <= 6'd0;
          end
        end else begin
          word_q[sweep_lane]          <= {6'd0, self_sh[sweep_lane], sweep_k};
          src_sh[sweep_lane][sweep_k] <= 6'd0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_VFPGA; g++) begin : g_lane
    assign route_ctrl[g*14 +: 14] = word_q[g];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_src  <= 6'd0;
      rd_self <= 6'd0;
    end else begin
      rd_src  <= ({1'b0, rd_vfpga} < LANE_LIM && {1'b0, rd_slot} < SLOT_LIM)
                 ? src_sh[rd_vfpga][rd_slot] : 6'd0;
      rd_self <= ({1'b0, rd_vfpga} < LANE_LIM) ? self_sh[rd_vfpga] : 6'd0;
    end
  end

endmodule
